// File: rtl/cond_pkg.sv
// Shared definitions for the ARM condition unit.
//   cond_e          : the 16 instruction condition encodings (Cond[31:28])
//   FLAG_N..FLAG_V  : bit positions of N,Z,C,V in a 4-bit flag vector,
//                     shared with the ALU so both sides agree on ordering
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator.
// Ports:
//   Cond   in  [3:0] instruction condition field
//   Flags  in  [3:0] N,Z,C,V flags to test against
//   CondEx out       1 when the condition passes
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  always_comb begin
    n = Flags[FLAG_N];
    z = Flags[FLAG_Z];
    c = Flags[FLAG_C];
    v = Flags[FLAG_V];
    CondEx = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ~(n ^ v);
      COND_LT: CondEx = n ^ v;
      COND_GT: CondEx = ~z & ~(n ^ v);
      COND_LE: CondEx = z | (n ^ v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition unit for the single-cycle ARM datapath: holds the NZCV flag
// register, evaluates the current instruction's condition against it,
// gates the architectural writes, and counts executed/squashed instructions.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    stage enable (low = stall, state holds)
//   flush                 squash the current instruction
//   in_valid              current instruction is valid
//   Cond[3:0]             condition field
//   FlagW[1:0]            bit1 writes N,Z; bit0 writes C,V
//   PCS, RegW, MemW       ungated write requests from the decoder
//   NoWrite               CMP-class: suppress RegWrite, flags still update
//   ALUFlags[3:0]         N,Z,C,V produced by the ALU this cycle
//   cnt_clr               synchronous clear of both counters
//   CondEx                condition passes against the registered Flags
//   PCSrc, RegWrite, MemWrite  gated writes (combinational)
//   Flags[3:0]            architectural flag register
//   exec_count, squash_count   performance counters (wrap, CNT_W bits)
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic [3:0]       ALUFlags,
  input  logic             cnt_clr,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] squash_count
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             go;

  // Condition is tested against the flags from before this instruction;
  // there is deliberately no bypass from ALUFlags.
  cond_check u_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  assign go       = in_valid & CondEx & ~flush;
  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & ~NoWrite & go;
  assign MemWrite = MemW & go;

  always_comb begin
    flags_d  = flags_q;
    exec_d   = exec_q;
    squash_d = squash_q;

    if (en && go) begin
      if (FlagW[1]) begin
        flags_d[FLAG_N] = ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
      end
      if (FlagW[0]) begin
        flags_d[FLAG_C] = ALUFlags[FLAG_C];
        flags_d[FLAG_V] = ALUFlags[FLAG_V];
      end
    end

    // Clear has priority and works even while stalled.
    if (cnt_clr) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (en && go) begin
      exec_d = exec_q + CNT_W'(1);
    end else if (en && in_valid) begin
      // valid but not executed: failed condition or flushed
      squash_d = squash_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign Flags        = flags_q;
  assign exec_count   = exec_q;
  assign squash_count = squash_q;

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Downstream consumer of the ALU's ALUFlags (N,Z,C,V = bits 3..0) in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register and evaluates the 4-bit condition field of the current instruction against it.
- Gates PCSrc/RegWrite/MemWrite and updates flags only for executed instructions.
- Keeps executed/squashed instruction counters for lab performance reporting.

Parameters:
CNT_W, 16, width of exec_count and squash_count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
en  input  1  stage enable; low = stall, no state change
flush  input  1  squash current instruction
in_valid  input  1  current instruction is valid
Cond  input  4  instruction condition field [31:28]
FlagW  input  2  bit1 = write N,Z; bit0 = write C,V
PCS  input  1  instruction writes PC
RegW  input  1  instruction writes register file
MemW  input  1  instruction writes memory
NoWrite  input  1  CMP-class: suppress RegWrite, flags still update
ALUFlags  input  4  N,Z,C,V from the ALU, current instruction
cnt_clr  input  1  synchronous clear of both counters
CondEx  output  1  condition passes against current Flags
PCSrc  output  1  gated PC write
RegWrite  output  1  gated register write
MemWrite  output  1  gated memory write
Flags  output  4  architectural N,Z,C,V register
exec_count  output  CNT_W  executed instructions
squash_count  output  CNT_W  valid instructions not executed

Behaviour:
- Clock and reset (fixed): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: Flags=4'b0000, exec_count=0, squash_count=0.
- Combinational outputs follow reset-state Flags and the inputs.
- CondEx is combinational from Cond and the registered Flags, i.e. the flags before this instruction:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0
- go = in_valid & CondEx & ~flush.
- Gated outputs (combinational, zero latency):
  - PCSrc = PCS & go
  - RegWrite = RegW & ~NoWrite & go
  - MemWrite = MemW & go
  - Outputs are not gated by en; the datapath ignores them while stalled.
- Flag update on rising clk when en & go:
  - FlagW[1]: Flags[3:2] <= ALUFlags[3:2]
  - FlagW[0]: Flags[1:0] <= ALUFlags[1:0]
  - Unselected bits hold.
  - The new flags become visible to CondEx the following cycle. There is no same-cycle bypass.
- Counters on rising clk:
  - cnt_clr=1: both counters <= 0. Clear wins over a simultaneous increment.
  - else en & go: exec_count +1.
  - else en & in_valid & (~CondEx | flush): squash_count +1.
  - Counters wrap modulo 2^CNT_W; no saturation.
- en=0: Flags and counters hold. cnt_clr is still honoured.
- in_valid=0: no flag or counter change; gated outputs 0.
- Reset asserted mid-cycle: Flags and counters clear immediately. Gated outputs then follow the cleared Flags (e.g. Cond=EQ gives CondEx=0).

Decomposition:
- Shared package cond_pkg holds:
  - cond_e enum for the 16 condition encodings
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, reused by the ALU and this block
- Natural sub-module: cond_check, purely combinational (Cond, Flags -> CondEx). It is reused by the verification model.
- Flag register, gating and counters stay in cond_unit.

Test Plan:
- Reset, then Cond=1110, FlagW=11, ALUFlags=0100, in_valid=1, en=1 -> CondEx=1; next cycle Flags=0100; exec_count=1.
- Flags=0100, Cond=0000 (EQ), PCS=1 -> PCSrc=1. Cond=0001 (NE) -> PCSrc=0, Flags hold, squash_count +1.
- Flags=1001, Cond=1010 (GE) -> CondEx=1. Flags=1000, Cond=1011 (LT) -> CondEx=1. Flags=1000, Cond=1100 (GT) -> CondEx=0.
- FlagW=10, ALUFlags=1011, old Flags=0100, Cond=AL -> Flags=1000 (C,V held). NoWrite=1, RegW=1 -> RegWrite=0, flags still update.
- en=0 with Cond=AL, FlagW=11, ALUFlags=1111 -> Flags and counters unchanged. Same with flush=1, en=1 -> all gated outputs 0, squash_count +1.
- CNT_W=4, 16 executed AL instructions -> exec_count wraps to 0. cnt_clr=1 on the same cycle as an executed instruction -> exec_count=0. rst_n pulsed low mid-cycle -> Flags=0000 immediately, without waiting for a clock edge.
